// File: rtl/hs32_execute.sv
// HS32 stage-3 execute: ALU + NZCV flags, registered packet to writeback; optional HS32_EXEC_MUL_EN multiplier.
// Latency: 1 cycle for ALU ops, 33 cycles for a multiply (HS32_EXEC_MUL_EN) from accept to valid_o.
// Backpressure: output held while valid_o & ~ready_i; ready_o low while held or multiplying.
module hs32_execute #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    // data_i = {d1[31:0], d2[31:0], neg, sub, cen, opr[1:0], fwe, rd[3:0], we1}
    input  logic [74:0] data_i,
    input  logic        mul_i,
    input  logic        flush_i,
    output logic        valid_o,
    input  logic        ready_i,
    // data_o = {res[31:0], rd[3:0], we}
    output logic [36:0] data_o,
    output logic [3:0]  rd3_o,
    output logic        stl3_o,
    output logic [3:0]  flags_o,
    output logic        err_o
);

    logic [31:0] d1, d2;
    logic        neg, sub, cen, fwe, we1;
    logic [1:0]  opr;
    logic [3:0]  rd;
    assign {d1, d2, neg, sub, cen, opr, fwe, rd, we1} = data_i;

    logic        valid_q, we_q, err_q;
    logic [31:0] res_q;
    logic [3:0]  rd_q, flags_q;
    logic        accept;

    // ALU
    logic [31:0] b, alu_res;
    logic [32:0] sum;
    logic        cin, alu_v;
    logic [3:0]  flags_nx;

    always_comb begin
        b        = neg ? ~d2 : d2;
        cin      = cen ? flags_q[1] : sub;
        sum      = {1'b0, d1} + {1'b0, b} + {32'd0, cin};
        alu_res  = sum[31:0];
        case (opr)
            2'd1:    alu_res = d1 & b;
            2'd2:    alu_res = d1 | b;
            2'd3:    alu_res = d1 ^ b;
            default: alu_res = sum[31:0];
        endcase
        alu_v    = (d1[31] == b[31]) & (sum[31] != d1[31]);
        flags_nx = flags_q;
        if (fwe) begin
            flags_nx[3] = alu_res[31];
            flags_nx[2] = (alu_res == 32'd0);
            if (opr == 2'd0) begin
                flags_nx[1] = sum[32];
                flags_nx[0] = alu_v;
            end
        end
    end

`ifdef HS32_EXEC_MUL_EN
    typedef enum logic {RUN, MUL} state_t;
    state_t      state, state_nx;
    logic [31:0] mcand, mplier, acc, acc_nx;
    logic [5:0]  cnt;
    logic [3:0]  m_rd;
    logic        m_we, m_fwe, mul_done;

    assign ready_o  = (state == RUN) & (~valid_q | ready_i);
    assign acc_nx   = acc + (mplier[0] ? mcand : 32'd0);
    assign mul_done = (state == MUL) & (cnt == 6'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (accept & mul_i) state_nx = MUL;
            MUL:     if (cnt == 6'd31)   state_nx = RUN;
            default: state_nx = RUN;
        endcase
        if (flush_i) state_nx = RUN;
    end

    // Shift-add: multiplicand walks left, multiplier walks right, one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= 6'd0;
            m_rd   <= 4'd0;
            m_we   <= 1'b0;
            m_fwe  <= 1'b0;
        end else if (accept & mul_i) begin
            mcand  <= d1;
            mplier <= d2;
            acc    <= 32'd0;
            cnt    <= 6'd0;
            m_rd   <= rd;
            m_we   <= we1;
            m_fwe  <= fwe;
        end else if (state == MUL) begin
            acc    <= acc_nx;
            mcand  <= {mcand[30:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
            cnt    <= cnt + 6'd1;
        end
    end
`else
    assign ready_o = ~valid_q | ready_i;
`endif

    assign accept = valid_i & ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= 32'd0;
            rd_q    <= 4'd0;
            we_q    <= 1'b0;
            flags_q <= RESET_FLAGS;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (accept & ~mul_i) begin
                valid_q <= 1'b1;
                res_q   <= alu_res;
                rd_q    <= rd;
                we_q    <= we1;
                flags_q <= flags_nx;
            end else if (accept & mul_i) begin
`ifdef HS32_EXEC_MUL_EN
                valid_q <= 1'b0;
`else
                valid_q <= 1'b1;
                res_q   <= 32'd0;
                rd_q    <= rd;
                we_q    <= we1;
                err_q   <= 1'b1;
`endif
`ifdef HS32_EXEC_MUL_EN
            end else if (mul_done) begin
                valid_q <= 1'b1;
                res_q   <= acc_nx;
                rd_q    <= m_rd;
                we_q    <= m_we;
                if (m_fwe) begin
                    flags_q[3] <= acc_nx[31];
                    flags_q[2] <= (acc_nx == 32'd0);
                end
`endif
            end else if (valid_q & ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = {res_q, rd_q, we_q};
    assign rd3_o   = rd_q;
    assign stl3_o  = valid_q & we_q;
    assign flags_o = flags_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_hs32_execute.sv
// Bench for hs32_execute: directed cases then random traffic against a transaction-level reference model.
module tb_hs32_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, mul_i, flush_i, valid_o, ready_i, stl3_o, err_o;
    logic [74:0] data_i;
    logic [36:0] data_o;
    logic [3:0]  rd3_o, flags_o;

    always #5 clk = ~clk;

    // stimulus fields
    logic [31:0] f_d1, f_d2;
    logic        f_neg, f_sub, f_cen, f_fwe, f_we;
    logic [1:0]  f_opr;
    logic [3:0]  f_rd;
    assign data_i = {f_d1, f_d2, f_neg, f_sub, f_cen, f_opr, f_fwe, f_rd, f_we};

    hs32_execute dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .mul_i(mul_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .rd3_o(rd3_o), .stl3_o(stl3_o),
        .flags_o(flags_o), .err_o(err_o)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model state
    logic        m_valid, m_we, m_err;
    logic [31:0] m_res;
    logic [3:0]  m_rd, m_flags;
    int          m_left;
    logic [31:0] m_prod;
    logic [3:0]  m_prd;
    logic        m_pwe, m_pfwe;

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_err = 0; m_res = 0; m_rd = 0;
        m_flags = 4'b0000; m_left = 0;
    endtask

    task automatic check_outputs();
        chk("valid_o", valid_o, m_valid);
        chk("res", data_o[36:5], m_res);
        chk("rd", data_o[4:1], m_rd);
        chk("we", data_o[0], m_we);
        chk("rd3_o", rd3_o, m_rd);
        chk("stl3_o", stl3_o, m_valid & m_we);
        chk("flags_o", flags_o, m_flags);
        chk("err_o", err_o, m_err);
    endtask

    // one clock: check ready_o, advance the model, then check registered outputs
    task automatic step();
        logic        rdy, acc;
        logic [31:0] b, r;
        logic [63:0] u;
        longint      s;
        #1;
        rdy = (m_left == 0) && (!m_valid || ready_i);
        chk("ready_o", ready_o, rdy);
        acc = valid_i && rdy;
        m_err = 0;
        if (flush_i) begin
            m_valid = 0;
            m_left  = 0;
        end else if (acc && !mul_i) begin
            b = f_neg ? ~f_d2 : f_d2;
            u = 64'(f_d1) + 64'(b) + 64'(f_cen ? m_flags[1] : f_sub);
            s = longint'($signed(f_d1)) + longint'($signed(b)) + longint'(f_cen ? m_flags[1] : f_sub);
            case (f_opr)
                2'd0: r = u[31:0];
                2'd1: r = f_d1 & b;
                2'd2: r = f_d1 | b;
                default: r = f_d1 ^ b;
            endcase
            if (f_fwe) begin
                m_flags[3] = r[31];
                m_flags[2] = (r == 0);
                if (f_opr == 0) begin
                    m_flags[1] = u[32];
                    m_flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
            end
            m_valid = 1; m_res = r; m_rd = f_rd; m_we = f_we;
        end else if (acc && mul_i) begin
`ifdef HS32_EXEC_MUL_EN
            m_valid = 0;
            m_left  = 32;
            m_prod  = f_d1 * f_d2;
            m_prd = f_rd; m_pwe = f_we; m_pfwe = f_fwe;
`else
            m_valid = 1; m_res = 0; m_rd = f_rd; m_we = f_we; m_err = 1;
`endif
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1; m_res = m_prod; m_rd = m_prd; m_we = m_pwe;
                if (m_pfwe) begin
                    m_flags[3] = m_prod[31];
                    m_flags[2] = (m_prod == 0);
                end
            end
        end else if (m_valid && ready_i) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_op(input logic [31:0] d1, input logic [31:0] d2, input logic neg,
                          input logic sub, input logic cen, input logic [1:0] opr,
                          input logic fwe, input logic [3:0] rd, input logic we);
        f_d1 = d1; f_d2 = d2; f_neg = neg; f_sub = sub; f_cen = cen;
        f_opr = opr; f_fwe = fwe; f_rd = rd; f_we = we;
        valid_i = 1; mul_i = 0; flush_i = 0;
    endtask

    logic [3:0]  saved_flags;
    logic [31:0] held;

    initial begin
        rst_n = 0; valid_i = 0; mul_i = 0; flush_i = 0; ready_i = 1;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        valid_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("ready_rst", ready_o, 1);
        rst_n = 1;

        // ADD overflow
        set_op(32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 1, 4'd5, 1);
        step();
        chk("add_res", data_o[36:5], 32'h80000000);
        chk("add_nzcv", flags_o, 4'b1001);
        chk("add_stl3", stl3_o, 1);
        chk("add_rd3", rd3_o, 4'd5);

        // SUB then ADC using the fresh carry
        set_op(32'd5, 32'd5, 1, 1, 0, 0, 1, 4'd2, 1);
        step();
        chk("sub_res", data_o[36:5], 0);
        chk("sub_nzcv", flags_o, 4'b0110);
        set_op(32'd1, 32'd1, 0, 0, 1, 0, 1, 4'd3, 1);
        step();
        chk("adc_res", data_o[36:5], 3);

        // BIC without flag write; rd=0 with we=1 still stalls decode
        saved_flags = flags_o;
        set_op(32'hFF, 32'h0F, 1, 0, 0, 1, 0, 4'd0, 1);
        step();
        chk("bic_res", data_o[36:5], 32'hF0);
        chk("bic_flags", flags_o, saved_flags);
        chk("rd0_stl3", stl3_o, 1);

        // back-pressure: hold then back-to-back reload
        valid_i = 0; step();
        ready_i = 0;
        set_op(32'h1234, 32'h1, 0, 0, 0, 0, 0, 4'd7, 1);
        step();
        held = data_o[36:5];
        set_op(32'hAAAA0000, 32'h5555, 0, 0, 0, 2, 0, 4'd8, 0);
        repeat (3) begin
            step();
            chk("hold_res", data_o[36:5], held);
        end
        ready_i = 1;
        step();
        chk("nobubble_res", data_o[36:5], 32'hAAAA5555);

        // flush drops both held and incoming packets
        saved_flags = flags_o;
        set_op(32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 1, 4'd9, 1);
        flush_i = 1;
        step();
        chk("flush_valid", valid_o, 0);
        chk("flush_flags", flags_o, saved_flags);
        flush_i = 0; valid_i = 0;
        step();

        // multiply, then multiply aborted by flush
        set_op(32'h10000, 32'h10001, 0, 0, 0, 0, 1, 4'd4, 1);
        mul_i = 1;
        step();
        valid_i = 0; mul_i = 0;
`ifdef HS32_EXEC_MUL_EN
        repeat (32) step();
        chk("mul_res", data_o[36:5], 32'h00010000);
        chk("mul_valid", valid_o, 1);
        set_op(32'h3, 32'h7, 0, 0, 0, 0, 1, 4'd4, 1);
        mul_i = 1;
        step();
        valid_i = 0; mul_i = 0;
        repeat (9) step();
        flush_i = 1;
        step();
        flush_i = 0;
        repeat (30) step();
        chk("mulabort_valid", valid_o, 0);
`else
        chk("mul_res", data_o[36:5], 0);
        chk("mul_err", err_o, 1);
        step();
        chk("mul_err_clr", err_o, 0);
`endif

        // asynchronous reset mid-operation
        set_op(32'h55, 32'h66, 0, 0, 0, 0, 1, 4'd6, 1);
        mul_i = 1;
        step();
        valid_i = 0; mul_i = 0;
        step();
        #2 rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            set_op($urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                   4'($urandom_range(0, 15)), $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f_d1 = 32'h80000000;
            if ($urandom_range(0, 7) == 0) f_d2 = 32'hFFFFFFFF;
            valid_i = ($urandom_range(0, 3) != 0);
            mul_i   = ($urandom_range(0, 15) == 0);
            flush_i = ($urandom_range(0, 24) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hs32_execute.md
Name: hs32_execute

Overview:
Stage 3 (execute) of the HS32 pipeline, directly downstream of stage 2 (decode2).
- Consumes the stage-2 packet: operands d1/d2, ALU control, destination rd, write enables.
- Computes the ALU result and updates the NZCV flag register.
- Registers the stage-3 packet for writeback.
- Drives the rd3/stl3 forwarding signals back to decode2.

Parameters:
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  stage-2 packet valid
ready_o  out  1  stage 3 can accept a packet this cycle
data_i  in  hs32_s2pkt  fields used: d1, d2, ctl{neg,sub,cen,opr,fwe}, rd, we1
mul_i  in  1  packet is a multiply (qualified by valid_i)
flush_i  in  1  discard held packet, abort multiply
valid_o  out  1  stage-3 packet valid
ready_i  in  1  writeback accepts packet
data_o  out  hs32_s3pkt  fields: res[31:0], rd[3:0], we
rd3_o  out  4  = data_o.rd
stl3_o  out  1  = valid_o & data_o.we; result pending, decode2 must forward
flags_o  out  4  NZCV register {N,Z,C,V}
err_o  out  1  one-cycle pulse on an illegal op

Behaviour:
- Reset (async, rst_n=0):
  - valid_o=0, data_o all zero, flags=RESET_FLAGS, FSM=RUN.
  - Hence stl3_o=0, rd3_o=0, err_o=0.
  - Reset asserted mid-multiply aborts it; no output is produced.
- FSM states: RUN, MUL.
- RUN:
  - ready_o = ~valid_o | ready_i.
  - Accept when valid_i & ready_o.
  - A non-mul accept loads the output register next edge: 1-cycle latency, valid_o=1.
- Output hold: valid_o & ~ready_i holds data_o stable; ready_o=0.
- Pop: valid_o & ready_i with no accept clears valid_o. Simultaneous pop+accept reloads the register back-to-back with no bubble.
- ALU, with b = ctl.neg ? ~d2 : d2:
  - opr=0 ADD: res = d1 + b + cin.
    - cin = ctl.cen ? C : ctl.sub.
    - 33-bit sum; carry out is bit 32.
  - opr=1 AND, opr=2 OR, opr=3 XOR: res = d1 op b.
- Flags, updated on accept (same edge as result capture) only if ctl.fwe:
  - N = res[31]; Z = (res==0).
  - C and V are updated only for opr=0:
    - C = carry out.
    - V = (d1[31]==b[31]) & (res[31]!=d1[31]).
  - Logic ops leave C and V unchanged.
  - fwe=0 leaves all flags unchanged.
  - A flag update is visible to the next accepted op's cin on the following cycle.
- Passthrough: data_o.rd = data_i.rd; data_o.we = data_i.we1.
- flush_i (priority over accept and pop):
  - Next edge: valid_o=0, FSM=RUN.
  - Incoming packet in the same cycle is dropped.
  - Flags already committed are not rolled back.
  - ready_o is unaffected combinationally.
- Boundary: packet with rd=0 and we=1 is handled normally; stl3_o still asserts.

Optional Feature:
HS32_EXEC_MUL_EN
- Defined:
  - A mul accept (only when valid_o=0, or it is being popped that cycle) enters MUL.
  - Radix-2 shift-add multiply: 32 iterations, 6-bit counter, one per cycle, over d1 x d2.
  - ready_o=0 throughout.
  - On completion: data_o.res = product[31:0], valid_o=1, FSM=RUN. Total latency 33 cycles from accept.
  - If ctl.fwe: N and Z are updated; C and V are unchanged.
  - flush_i in MUL aborts to RUN with valid_o=0.
- Undefined:
  - Mul accept produces res=0 with valid_o=1 after 1 cycle and err_o=1 for one cycle.
  - Flags are unchanged.
  - No MUL state is synthesized.

Test Plan:
- ADD 0x7FFFFFFF + 1, fwe=1 → res=0x80000000, NZCV=1001, valid_o next cycle, stl3_o=1 with rd3_o=rd.
- SUB (neg=1, sub=1) d1=5, d2=5, fwe=1 → res=0, NZCV=0110; then ADC (cen=1) 1+1 → res=3.
- BIC (opr=1, neg=1) d1=0xFF, d2=0x0F, fwe=0 → res=0xF0, flags unchanged.
- Back-pressure: ready_i=0 for 3 cycles with valid_i=1 → data_o stable, ready_o=0; ready_i=1 → next packet loaded with no bubble.
- flush_i while valid_o=1 and valid_i=1 → valid_o=0 next cycle, both packets lost, flags keep committed value.
- Multiply:
  - With HS32_EXEC_MUL_EN: 0x10000 x 0x10001 → res=0x00010000 after 33 cycles; flush at cycle 10 aborts with valid_o=0.
  - Without HS32_EXEC_MUL_EN: same stimulus gives err_o pulse and res=0.
